// File: rtl/nanov_digit_alu.sv
// Digit-serial RV32I ALU, DIGIT_W bits/beat LSB first; results N cycles (single-pass) or 2N cycles (two-pass) after start.
// No backpressure: start is taken only while busy=0. Shifts are built only with NANOV_DIGIT_SHIFT_EN defined.
module nanov_digit_alu #(
    parameter int DIGIT_W = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic [DIGIT_W-1:0] res_digit,
    output logic               res_valid,
    output logic               busy,
    output logic               done
);
    localparam int N  = 32 / DIGIT_W;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] OUTPUT  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [3:0]         op_q;
    logic               carry;
    logic               lt_q;

    logic               accept;
    logic               cap;
    logic [3:0]         op_cur;
    logic [2:0]         f3;
    logic               subtract;
    logic               two_pass;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] alu_dig;
    logic [DIGIT_W-1:0] shift_dig;
    logic [DIGIT_W-1:0] out_dig;
    logic               lt_now;

    // Beat 0 is consumed in the start cycle itself, so op comes straight from the port there.
    assign accept   = (state == IDLE) && start && !busy;
    assign cap      = accept || (state == CAPTURE);
    assign op_cur   = (state == IDLE) ? op : op_q;
    assign f3       = op_cur[2:0];
    assign subtract = ((f3 == 3'b000) && op_cur[3]) || (f3 == 3'b010) || (f3 == 3'b011);
    assign two_pass = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011) || (f3 == 3'b101);

    assign b_eff = subtract ? ~b_digit : b_digit;
    assign sum   = {1'b0, a_digit} + {1'b0, b_eff}
                 + {{DIGIT_W{1'b0}}, ((state == IDLE) ? subtract : carry)};

    always_comb begin
        alu_dig = sum[DIGIT_W-1:0];
        case (f3)
            3'b100:  alu_dig = a_digit ^ b_digit;
            3'b110:  alu_dig = a_digit | b_digit;
            3'b111:  alu_dig = a_digit & b_digit;
            default: alu_dig = sum[DIGIT_W-1:0];
        endcase
    end

    // SLTU: borrow out of a-b; SLT: sign of a when signs differ, else sign of the difference.
    assign lt_now = f3[0] ? ~sum[DIGIT_W]
                  : ((a_digit[DIGIT_W-1] != b_digit[DIGIT_W-1]) ? a_digit[DIGIT_W-1]
                                                                : sum[DIGIT_W-1]);

`ifdef NANOV_DIGIT_SHIFT_EN
    logic [31:0] sbuf;
    logic [31:0] shifted;
    logic [4:0]  shamt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sbuf  <= '0;
            shamt <= '0;
        end else if (cap) begin
            sbuf <= {a_digit, sbuf[31:DIGIT_W]};
            for (int i = 0; i < 5; i++) begin
                if (cnt == CW'(i / DIGIT_W))
                    shamt[i] <= b_digit[i % DIGIT_W];
            end
        end
    end

    always_comb begin
        shifted = sbuf >> shamt;
        if (op_q[2:0] == 3'b001)
            shifted = sbuf << shamt;
        else if (op_q[3])
            shifted = 32'($signed(sbuf) >>> shamt);
    end

    assign shift_dig = shifted[int'(cnt) * DIGIT_W +: DIGIT_W];
`else
    assign shift_dig = '0;
`endif

    always_comb begin
        out_dig = shift_dig;
        if (op_q[2:1] == 2'b01) begin
            out_dig    = '0;
            out_dig[0] = lt_q && (cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            carry     <= 1'b0;
            lt_q      <= 1'b0;
            res_digit <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            res_digit <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            if (done)
                busy <= 1'b0;
            if (cap) begin
                carry <= sum[DIGIT_W];
                if (!two_pass) begin
                    res_valid <= 1'b1;
                    res_digit <= alu_dig;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        busy  <= 1'b1;
                        cnt   <= CW'(1);
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        lt_q <= lt_now;
                        if (two_pass) begin
                            state <= OUTPUT;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUTPUT: begin
                    res_valid <= 1'b1;
                    res_digit <= out_dig;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_digit_alu.sv
// Directed bench for nanov_digit_alu: one instance per legal DIGIT_W (1, 2, 4, 8) sharing stimulus, selected by sel.
module tb_nanov_digit_alu;
`ifdef NANOV_DIGIT_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [1:0] sel;
    logic [3:0] op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] res_v   [4];
    logic       valid_v [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    int         npass  = 0;
    int         nfail  = 0;
    int         ntotal = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = 1 << g;
        logic [W-1:0] rd;
        logic         st;
        assign st = start && (sel == 2'(g));
        nanov_digit_alu #(.DIGIT_W(W)) dut (
            .clk       (clk),
            .rstn      (rstn),
            .start     (st),
            .op        (op),
            .a_digit   (a_in[W-1:0]),
            .b_digit   (b_in[W-1:0]),
            .res_digit (rd),
            .res_valid (valid_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g])
        );
        assign res_v[g] = 8'(rd);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one operation on instance g starting at the next cycle; extra = cycle of a spurious
    // start (op altered), rst_at = cycle in which rstn is driven low (-1 for none).
    task automatic run_op(input int g, input logic [3:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input bit two, input int extra,
                          input int rst_at, input string tag, output logic [31:0] res);
        int w, n, first, last, stop;
        bit live, v;
        w     = 1 << g;
        n     = 32 / w;
        first = two ? n + 1 : 1;
        last  = two ? 2 * n : n;
        stop  = (rst_at >= 0) ? rst_at + 1 : last + 1;
        res   = '0;
        for (int c = 0; c <= stop; c++) begin
            @(negedge clk);
            live = !(rst_at >= 0 && c > rst_at);
            v    = live && c >= first && c <= last;
            chk({tag, " valid"}, 32'(valid_v[g]), 32'(v));
            chk({tag, " done"},  32'(done_v[g]),  32'(live && c == last));
            chk({tag, " busy"},  32'(busy_v[g]),  32'(live && c >= 1 && c <= last));
            if (v) begin
                for (int j = 0; j < w; j++)
                    res[(c - first) * w + j] = res_v[g][j];
            end else begin
                chk({tag, " idle digit"}, 32'(res_v[g]), 32'h0);
            end
            sel   = 2'(g);
            start = (c == 0) || (c == extra);
            op    = (c == extra) ? (opc ^ 4'b0100) : opc;
            a_in  = (c < n) ? 8'(a >> (c * w)) : 8'h00;
            b_in  = (c < n) ? 8'(b >> (c * w)) : 8'h00;
            rstn  = (c != rst_at);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rstn  = 1'b0;
        start = 1'b0;
        sel   = 2'd0;
        op    = 4'd0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("reset busy",  32'(busy_v[g]),  32'h0);
            chk("reset valid", 32'(valid_v[g]), 32'h0);
            chk("reset done",  32'(done_v[g]),  32'h0);
            chk("reset digit", 32'(res_v[g]),   32'h0);
        end
        rstn = 1'b1;

        run_op(2, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0, -1, -1, "add w4", r);
        chk("add w4 result", r, 32'h80000000);
        run_op(3, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, -1, -1, "add w8 wrap", r);
        chk("add w8 wrap result", r, 32'h00000000);
        run_op(0, 4'b1000, 32'h00000005, 32'h00000007, 1'b0, -1, -1, "sub w1", r);
        chk("sub w1 result", r, 32'hFFFFFFFE);
        run_op(2, 4'b0100, 32'hF0F01234, 32'h0FF0FF00, 1'b0, -1, -1, "xor w4", r);
        chk("xor w4 result", r, 32'hFF00ED34);
        run_op(2, 4'b1100, 32'hF0F01234, 32'h0FF0FF00, 1'b0, -1, -1, "xor mod w4", r);
        chk("xor mod w4 result", r, 32'hFF00ED34);
        run_op(1, 4'b0110, 32'hF0F01234, 32'h0FF0FF00, 1'b0, -1, -1, "or w2", r);
        chk("or w2 result", r, 32'hFFF0FF34);
        run_op(3, 4'b0111, 32'hF0F01234, 32'h0FF0FF00, 1'b0, -1, -1, "and w8", r);
        chk("and w8 result", r, 32'h00F01200);

        run_op(1, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b1, -1, -1, "slt w2", r);
        chk("slt w2 result", r, 32'h00000001);
        run_op(1, 4'b0011, 32'hFFFFFFFF, 32'h00000001, 1'b1, -1, -1, "sltu w2", r);
        chk("sltu w2 result", r, 32'h00000000);
        run_op(2, 4'b0010, 32'h00000001, 32'hFFFFFFFF, 1'b1, -1, -1, "slt w4", r);
        chk("slt w4 result", r, 32'h00000000);
        run_op(2, 4'b0011, 32'h00000001, 32'hFFFFFFFF, 1'b1, -1, -1, "sltu w4", r);
        chk("sltu w4 result", r, 32'h00000001);
        run_op(3, 4'b0010, 32'h00000003, 32'h00000005, 1'b1, -1, -1, "slt w8 lt", r);
        chk("slt w8 lt result", r, 32'h00000001);
        run_op(0, 4'b0010, 32'h00000005, 32'h00000005, 1'b1, -1, -1, "slt w1 eq", r);
        chk("slt w1 eq result", r, 32'h00000000);

        run_op(3, 4'b1101, 32'h80000000, 32'h00000004, 1'b1, -1, -1, "sra w8", r);
        chk("sra w8 result", r, SH ? 32'hF8000000 : 32'h0);
        run_op(3, 4'b0001, 32'h00000001, 32'h0000001F, 1'b1, -1, -1, "sll w8", r);
        chk("sll w8 result", r, SH ? 32'h80000000 : 32'h0);
        run_op(3, 4'b0101, 32'h80000000, 32'h0000001F, 1'b1, -1, -1, "srl w8", r);
        chk("srl w8 result", r, SH ? 32'h00000001 : 32'h0);
        run_op(2, 4'b0101, 32'h80000000, 32'hFFFFFFE4, 1'b1, -1, -1, "srl w4 imm", r);
        chk("srl w4 imm result", r, SH ? 32'h08000000 : 32'h0);
        run_op(0, 4'b1101, 32'h00001234, 32'h00000000, 1'b1, -1, -1, "sra w1 zero", r);
        chk("sra w1 zero result", r, SH ? 32'h00001234 : 32'h0);

        run_op(2, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 3, -1, "add w4 restart", r);
        chk("add w4 restart result", r, 32'h80000000);
        run_op(2, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b1, 16, -1, "slt w4 done start", r);
        chk("slt w4 done start result", r, 32'h00000001);
        run_op(2, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b1, -1, 5, "slt w4 abort", r);
        run_op(2, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b1, -1, -1, "slt w4 after rst", r);
        chk("slt w4 after rst result", r, 32'h00000001);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
